// File: rtl/neander_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths and FSM state encoding.
package neander_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, otherwise the port not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b10) begin
      grant = 1'b1;
    end else if (req == 2'b11) begin
      grant = ~last;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one external single-port RAM between a CPU port and a loader port.
module mem_arbiter
  import neander_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t              state;
  logic                last;
  logic                sel;
  logic                grant;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   rdata_q;

  rr_pick2 u_pick (
    .req   ({req1, req0}),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      sel       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state     <= ACCESS;
            sel       <= grant;
            lat_we    <= grant ? we1 : we0;
            lat_addr  <= grant ? addr1 : addr0;
            lat_wdata <= grant ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          if (!lat_we) begin
            rdata_q <= ram_rdata;
          end
          state <= DONE;
        end
        DONE: begin
          last  <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rst_n gates the strobes directly so a reset landing mid-access cannot write or ack.
  assign ram_we    = rst_n && (state == ACCESS) && lat_we;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  assign ack0      = rst_n && (state == DONE) && !sel;
  assign ack1      = rst_n && (state == DONE) && sel;
  assign busy      = rst_n && (state != IDLE);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter with a RAM model and a transaction-level reference.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, ram_we;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // External RAM: synchronous write, combinational read.
  logic [DW-1:0] mem [256] = '{default: '0};
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  // Reference: expected memory image, last-served port, expected rdata, scoreboard counts.
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  bit            model_last = 1'b1;
  logic [DW-1:0] exp_rdata = '0;
  int            n_cmp = 0, n_fail = 0;
  int            acks0 = 0, acks1 = 0, reqs0 = 0, reqs1 = 0;
  int            win_log[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One access from IDLE through DONE; the winner is predicted from the arbitration rule.
  task automatic step_txn(input bit keep, input bit scramble);
    int            win;
    bit            w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    if (req0 && req1) win = model_last ? 0 : 1;
    else              win = req1 ? 1 : 0;
    w_we   = (win == 1) ? we1 : we0;
    w_addr = (win == 1) ? addr1 : addr0;
    w_data = (win == 1) ? wdata1 : wdata0;
    if (win == 0) reqs0++; else reqs1++;
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_ram_we", {31'b0, ram_we}, 32'd0);
    tick();
    check("acc_busy", {31'b0, busy}, 32'd1);
    check("acc_ram_we", {31'b0, ram_we}, {31'b0, w_we});
    check("acc_ram_addr", {24'b0, ram_addr}, {24'b0, w_addr});
    if (w_we) check("acc_ram_wdata", {16'b0, ram_wdata}, {16'b0, w_data});
    if (scramble) begin
      if (win == 0) begin addr0 = addr0 + 8'd1; wdata0 = DW'($urandom); we0 = ~we0; end
      else          begin addr1 = addr1 + 8'd1; wdata1 = DW'($urandom); we1 = ~we1; end
    end
    if (w_we) ref_mem[w_addr] = w_data;
    else      exp_rdata = ref_mem[w_addr];
    tick();
    check("done_ack0", {31'b0, ack0}, {31'b0, win == 0});
    check("done_ack1", {31'b0, ack1}, {31'b0, win == 1});
    check("done_rdata", {16'b0, rdata}, {16'b0, exp_rdata});
    check("done_ram_we", {31'b0, ram_we}, 32'd0);
    check("done_busy", {31'b0, busy}, 32'd1);
    if (ack0) acks0++;
    if (ack1) acks1++;
    if (!keep) begin
      if (win == 0) req0 = 1'b0; else req1 = 1'b0;
    end
    model_last = win[0];
    win_log.push_back(win);
    tick();
  endtask

  task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d;
    step_txn(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r0, r1;
    int base;

    // Reset with a pending write request: nothing may happen.
    rst_n = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 8'h44; wdata0 = 16'hDEAD;
    tick(); tick(); tick();
    check("rst_ack0", {31'b0, ack0}, 32'd0);
    check("rst_ack1", {31'b0, ack1}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rdata", {16'b0, rdata}, 32'd0);
    check("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check("rst_ram_addr", {24'b0, ram_addr}, 32'd0);
    req0 = 1'b0;
    rst_n = 1'b1;
    tick();

    // Port 0 writes 0xBEEF to 0x10.
    write0(8'h10, 16'hBEEF);
    check("mem_10", {16'b0, mem[8'h10]}, 32'h0000BEEF);

    // Port 1 reads it back.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
    step_txn(1'b0, 1'b0);
    check("rd_beef", {16'b0, rdata}, 32'h0000BEEF);

    // Preload through the arbiter.
    write0(8'h30, DW'($urandom));
    write0(8'h31, DW'($urandom));
    write0(8'h05, 16'h0505);
    write0(8'h06, 16'h0606);
    write0(8'h20, 16'h5A5A);

    // Reset lands in the ACCESS cycle of a write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'h1234;
    tick();
    check("abort_we_before", {31'b0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_we_gated", {31'b0, ram_we}, 32'd0);
    tick();
    check("abort_ack0", {31'b0, ack0}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_mem_20", {16'b0, mem[8'h20]}, 32'h00005A5A);
    check("abort_busy_after", {31'b0, busy}, 32'd0);
    check("abort_rdata", {16'b0, rdata}, 32'd0);
    model_last = 1'b1;
    exp_rdata = '0;

    // Both ports held from reset, reading distinct addresses.
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
    tick(); tick();
    rst_n = 1'b1;
    model_last = 1'b1;
    exp_rdata = '0;
    base = win_log.size();
    step_txn(1'b1, 1'b0);
    step_txn(1'b1, 1'b0);
    step_txn(1'b1, 1'b0);
    step_txn(1'b0, 1'b0);
    req0 = 1'b0;
    check("order_0", win_log[base],     32'd0);
    check("order_1", win_log[base + 1], 32'd1);
    check("order_2", win_log[base + 2], 32'd0);
    check("order_3", win_log[base + 3], 32'd1);
    tick();

    // Address changes during ACCESS must not disturb the latched read.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    step_txn(1'b0, 1'b1);
    check("latched_rd_05", {16'b0, rdata}, 32'h00000505);

    // req0 held one cycle past its ack is a second request.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h06;
    step_txn(1'b1, 1'b0);
    step_txn(1'b0, 1'b0);
    check("rehold_rdata", {16'b0, rdata}, 32'h00000606);

    // Randomized traffic with contention and mid-access input changes.
    for (int i = 0; i < 40; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      req0 = r0; we0 = 1'($urandom); addr0 = 8'h40 + AW'($urandom_range(0, 7)); wdata0 = DW'($urandom);
      req1 = r1; we1 = 1'($urandom); addr1 = 8'h40 + AW'($urandom_range(0, 7)); wdata1 = DW'($urandom);
      while (req0 || req1) step_txn(1'b0, 1'($urandom));
    end
    for (int a = 8'h40; a < 8'h48; a++)
      check("rand_mem", {16'b0, mem[a]}, {16'b0, ref_mem[a]});

    check("ack0_count", acks0, reqs0);
    check("ack1_count", acks1, reqs1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
